// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : Write-back stage and 32 x DATA_W integer register file.
//                Selects load data or ALU result for write-back, commits it,
//                serves two decode read ports with same-cycle bypass, a
//                non-bypassed debug read port and a committed-write counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Mem_WB_MemtoReg,
    input  logic              Mem_WB_RegWrite,
    input  logic [DATA_W-1:0] Mem_WB_Read_Data,
    input  logic [DATA_W-1:0] Mem_WB_ALU_Result,
    input  logic [4:0]        Mem_WB_rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WB_Data,
    input  logic [4:0]        Dbg_addr,
    output logic [DATA_W-1:0] Dbg_data,
    output logic [CNT_W-1:0]  WB_Count
);

    // Storage for x1..x31; x0 is not stored, it is a constant zero.
    logic [DATA_W-1:0] regs_q [1:31];
    // Full 32-entry view of the file with x0 tied to zero.
    logic [DATA_W-1:0] rf     [32];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              commit;

    // Write-back value select; purely combinational so it tracks its inputs
    // even while reset is held.
    always_comb begin
        WB_Data = Mem_WB_MemtoReg ? Mem_WB_Read_Data : Mem_WB_ALU_Result;
    end

    // A write commits only when enabled, aimed at a real register and not in reset.
    always_comb begin
        commit  = Mem_WB_RegWrite && (Mem_WB_rd != 5'd0) && !reset;
        count_d = commit ? count_q + CNT_W'(1) : count_q;
    end

    // One flop bank per architectural register, each with its own write decode.
    generate
        for (genvar i = 1; i < 32; i++) begin : g_reg
            // Register i captures WB_Data when the committing write targets it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    regs_q[i] <= '0;
                end else if (commit && (Mem_WB_rd == 5'(i))) begin
                    regs_q[i] <= WB_Data;
                end
            end
        end
    endgenerate

    // Committed-write counter; wraps naturally modulo 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Build the addressable view so every read can index 0..31 safely.
    always_comb begin
        rf[0] = '0;
        for (int i = 1; i < 32; i++) begin
            rf[i] = regs_q[i];
        end
    end

    // Read port 1: zero in reset or for x0, bypass a same-cycle commit, else array.
    always_comb begin
        ReadData1 = '0;
        if (reset || (rs1 == 5'd0)) begin
            ReadData1 = '0;
        end else if (commit && (Mem_WB_rd == rs1)) begin
            ReadData1 = WB_Data;
        end else begin
            ReadData1 = rf[rs1];
        end
    end

    // Read port 2: identical policy to port 1 so both bypass the same way.
    always_comb begin
        ReadData2 = '0;
        if (reset || (rs2 == 5'd0)) begin
            ReadData2 = '0;
        end else if (commit && (Mem_WB_rd == rs2)) begin
            ReadData2 = WB_Data;
        end else begin
            ReadData2 = rf[rs2];
        end
    end

    // Debug port reads committed state only; a write shows up after its edge.
    always_comb begin
        Dbg_data = reset ? '0 : rf[Dbg_addr];
    end

    assign WB_Count = count_q;

endmodule
`default_nettype wire
